paddle_motion: RTL and testbench

Parametrised, multi-channel successor to the single-paddle controller. It converts per-player rotary-encoder events or held left/right buttons into clamped paddle X coordinates. It applies direction-consistent acceleration and re-clamps paddles whenever their radius changes. It sits between the input debouncers and the renderer/collision logic, and supplies one paddle per player.

---
 rtl/paddle_pkg.sv | 29 ++
 rtl/paddle_channel.sv | 159 +++++++++++++++
 rtl/paddle_motion.sv | 66 ++++++
 tb/tb_paddle_motion.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/paddle_pkg.sv
// Shared definitions for the paddle motion controller: mode encodings,
// bus field widths, move direction and the per-channel home position.
package paddle_pkg;

  localparam logic MODE_ROTARY = 1'b0;
  localparam logic MODE_BUTTON = 1'b1;

  localparam int unsigned SPEED_W  = 5;
  localparam int unsigned RADIUS_W = 6;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Centre of the idx-th of n equal slices across the playfield width.
  function automatic int unsigned home_x(input int unsigned left, input int unsigned maxx,
                                         input int unsigned n, input int unsigned idx);
    return left + (maxx * (2 * idx + 1)) / (2 * n);
  endfunction

  // Channel rows stack upward from the bottom of the playfield.
  function automatic int unsigned home_y(input int unsigned top, input int unsigned maxy,
                                         input int unsigned pd_h, input int unsigned row_gap,
                                         input int unsigned idx);
    return top + maxy - pd_h - idx * row_gap;
  endfunction

endpackage

// File: rtl/paddle_channel.sv
// One paddle channel: button hold timer, direction-streak acceleration,
// bounded moves, re-clamping on radius change and bound flags.
module paddle_channel
  import paddle_pkg::*;
#(
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned LEFT          = 160,
  parameter int unsigned MAXX          = 320,
  parameter int unsigned ACCEL_WINDOW  = 2_500_000,
  parameter int unsigned ACCEL_MAX_LVL = 2,
  parameter int unsigned HOLD_PERIOD   = 1_250_000,
  parameter int unsigned HOME_X        = 320,
  parameter int unsigned HOME_Y        = 472
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                recenter,
  input  logic                mode,
  input  logic                rotary_event,
  input  logic                rotary_right,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic [SPEED_W-1:0]  speed,
  input  logic [RADIUS_W-1:0] radius,
  output logic [COORD_W-1:0]  paddle_x,
  output logic [COORD_W-1:0]  paddle_y,
  output logic                at_left,
  output logic                at_right,
  output logic                move_pulse
);

  localparam int unsigned XW = COORD_W + 2;
  localparam int unsigned SW = SPEED_W + ACCEL_MAX_LVL;
  localparam int unsigned LW = (ACCEL_MAX_LVL > 0) ? $clog2(ACCEL_MAX_LVL + 1) : 1;
  localparam int unsigned GW = $clog2(ACCEL_WINDOW + 1);
  localparam int unsigned TW = $clog2(HOLD_PERIOD + 1);

  logic [LW-1:0] lvl_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] tmr_q;
  logic          mode_q;
  dir_e          dir_q;

  logic          mode_change;
  logic [LW-1:0] lvl_base;
  logic [LW-1:0] lvl_idle;
  logic [LW-1:0] lvl_move;
  logic [TW-1:0] tmr_base;
  logic [TW-1:0] tmr_next;
  logic          req;
  dir_e          dir;
  logic          streak;
  logic [SW-1:0] step;
  logic [XW-1:0] xe;
  logic [XW-1:0] lo;
  logic [XW-1:0] hi;
  logic [XW-1:0] moved;
  logic [XW-1:0] clamped;
  logic [COORD_W-1:0] x_next;

  assign paddle_y = COORD_W'(HOME_Y);

  // Move request, acceleration level and next X for this cycle.
  always_comb begin
    // A mode switch behaves as if timer and level had already been cleared,
    // so the first cycle in the new mode follows that mode's rules.
    mode_change = (mode != mode_q);
    lvl_base    = mode_change ? '0 : lvl_q;
    tmr_base    = mode_change ? '0 : tmr_q;
    lvl_idle    = lvl_base;
    tmr_next    = '0;
    req         = 1'b0;
    dir         = DIR_LEFT;

    if (mode == MODE_ROTARY) begin
      req = rotary_event;
      dir = rotary_right ? DIR_RIGHT : DIR_LEFT;
    end else if (btn_left ^ btn_right) begin
      req      = (tmr_base == '0);
      dir      = btn_right ? DIR_RIGHT : DIR_LEFT;
      tmr_next = (tmr_base == TW'(HOLD_PERIOD - 1)) ? '0 : tmr_base + TW'(1);
    end else begin
      lvl_idle = '0;
    end

    // gap_q counts idle cycles after the last move, so the distance between
    // two move cycles is gap_q + 1.
    streak = (dir == dir_q) && (gap_q < GW'(ACCEL_WINDOW - 1));
    if (!streak)
      lvl_move = '0;
    else if (lvl_base >= LW'(ACCEL_MAX_LVL))
      lvl_move = LW'(ACCEL_MAX_LVL);
    else
      lvl_move = lvl_base + LW'(1);

    step = SW'(speed) << lvl_move;
    xe   = XW'(paddle_x);
    lo   = XW'(LEFT) + XW'(radius);
    hi   = XW'(LEFT + MAXX) - XW'(radius);

    if (dir == DIR_RIGHT)
      moved = (xe + XW'(step) + XW'(radius) < XW'(LEFT + MAXX)) ? xe + XW'(step) : hi;
    else
      moved = (xe > lo + XW'(step)) ? xe - XW'(step) : lo;

    clamped = xe;
    if (clamped < lo) clamped = lo;
    if (clamped > hi) clamped = hi;

    if (recenter)
      x_next = COORD_W'(HOME_X);
    else if (!enable)
      x_next = paddle_x;
    else if (req)
      x_next = COORD_W'(moved);
    else
      x_next = COORD_W'(clamped);
  end

  // Position, flags and acceleration/timer state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      paddle_x   <= COORD_W'(HOME_X);
      at_left    <= 1'b0;
      at_right   <= 1'b0;
      move_pulse <= 1'b0;
      lvl_q      <= '0;
      gap_q      <= GW'(ACCEL_WINDOW);
      tmr_q      <= '0;
      mode_q     <= MODE_ROTARY;
      dir_q      <= DIR_LEFT;
    end else begin
      paddle_x <= x_next;
      at_left  <= (XW'(x_next) == lo);
      at_right <= (XW'(x_next) == hi);
      mode_q   <= mode;
      if (recenter || !enable) begin
        lvl_q      <= '0;
        gap_q      <= '0;
        tmr_q      <= '0;
        move_pulse <= 1'b0;
      end else begin
        tmr_q      <= tmr_next;
        move_pulse <= req && (moved != xe);
        if (req) begin
          lvl_q <= lvl_move;
          gap_q <= '0;
          dir_q <= dir;
        end else begin
          lvl_q <= lvl_idle;
          if (gap_q != GW'(ACCEL_WINDOW))
            gap_q <= gap_q + GW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/paddle_motion.sv
// Multi-channel paddle controller: one independent paddle_channel per player,
// with per-channel fields packed into shared buses (channel 0 in the LSBs).
module paddle_motion
  import paddle_pkg::*;
#(
  parameter int unsigned NUM_PADDLES   = 1,
  parameter int unsigned COORD_W       = 10,
  parameter int unsigned LEFT          = 160,
  parameter int unsigned MAXX          = 320,
  parameter int unsigned TOP           = 0,
  parameter int unsigned MAXY          = 480,
  parameter int unsigned PD_H          = 8,
  parameter int unsigned ROW_GAP       = 16,
  parameter int unsigned ACCEL_WINDOW  = 2_500_000,
  parameter int unsigned ACCEL_MAX_LVL = 2,
  parameter int unsigned HOLD_PERIOD   = 1_250_000
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic                            recenter,
  input  logic                            mode,
  input  logic [NUM_PADDLES-1:0]          rotary_event,
  input  logic [NUM_PADDLES-1:0]          rotary_right,
  input  logic [NUM_PADDLES-1:0]          btn_left,
  input  logic [NUM_PADDLES-1:0]          btn_right,
  input  logic [SPEED_W-1:0]              speed,
  input  logic [RADIUS_W*NUM_PADDLES-1:0] radius,
  output logic [COORD_W*NUM_PADDLES-1:0]  paddle_x,
  output logic [COORD_W*NUM_PADDLES-1:0]  paddle_y,
  output logic [NUM_PADDLES-1:0]          at_left,
  output logic [NUM_PADDLES-1:0]          at_right,
  output logic [NUM_PADDLES-1:0]          move_pulse
);

  for (genvar i = 0; i < NUM_PADDLES; i++) begin : g_ch
    paddle_channel #(
      .COORD_W      (COORD_W),
      .LEFT         (LEFT),
      .MAXX         (MAXX),
      .ACCEL_WINDOW (ACCEL_WINDOW),
      .ACCEL_MAX_LVL(ACCEL_MAX_LVL),
      .HOLD_PERIOD  (HOLD_PERIOD),
      .HOME_X       (home_x(LEFT, MAXX, NUM_PADDLES, i)),
      .HOME_Y       (home_y(TOP, MAXY, PD_H, ROW_GAP, i))
    ) u_ch (
      .clock       (clock),
      .reset_n     (reset_n),
      .enable      (enable),
      .recenter    (recenter),
      .mode        (mode),
      .rotary_event(rotary_event[i]),
      .rotary_right(rotary_right[i]),
      .btn_left    (btn_left[i]),
      .btn_right   (btn_right[i]),
      .speed       (speed),
      .radius      (radius[RADIUS_W*i +: RADIUS_W]),
      .paddle_x    (paddle_x[COORD_W*i +: COORD_W]),
      .paddle_y    (paddle_y[COORD_W*i +: COORD_W]),
      .at_left     (at_left[i]),
      .at_right    (at_right[i]),
      .move_pulse  (move_pulse[i])
    );
  end

endmodule

// File: tb/tb_paddle_motion.sv
// Bench for paddle_motion: directed vector table on a single-channel instance,
// hand sequences for holds/enable/recenter/reset, and randomized traffic on a
// two-channel instance checked against a cycle-level reference model.
module tb_paddle_motion;

  localparam int W = 40;  // shortened acceleration window
  localparam int P = 20;  // shortened hold repeat period

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // single-channel instance
  logic       en1, rc1, md1;
  logic [0:0] ev1, rr1, bl1, br1;
  logic [4:0] sp1;
  logic [5:0] rad1;
  logic [9:0] x1, y1;
  logic [0:0] al1, ar1, mp1;

  // two-channel instance
  logic        en2, rc2, md2;
  logic [1:0]  ev2, rr2, bl2, br2;
  logic [4:0]  sp2;
  logic [11:0] rad2;
  logic [19:0] x2, y2;
  logic [1:0]  al2, ar2, mp2;

  paddle_motion #(.NUM_PADDLES(1), .ACCEL_WINDOW(W), .HOLD_PERIOD(P)) d1 (
    .clock(clock), .reset_n(reset_n), .enable(en1), .recenter(rc1), .mode(md1),
    .rotary_event(ev1), .rotary_right(rr1), .btn_left(bl1), .btn_right(br1),
    .speed(sp1), .radius(rad1), .paddle_x(x1), .paddle_y(y1),
    .at_left(al1), .at_right(ar1), .move_pulse(mp1));

  paddle_motion #(.NUM_PADDLES(2), .ACCEL_WINDOW(W), .HOLD_PERIOD(P)) d2 (
    .clock(clock), .reset_n(reset_n), .enable(en2), .recenter(rc2), .mode(md2),
    .rotary_event(ev2), .rotary_right(rr2), .btn_left(bl2), .btn_right(br2),
    .speed(sp2), .radius(rad2), .paddle_x(x2), .paddle_y(y2),
    .at_left(al2), .at_right(ar2), .move_pulse(mp2));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    int idle; bit ev; bit right; int spd; int rad;
    int ex; bit al; bit ar; bit mp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int idle, bit ev, bit right, int spd, int rad,
                              int ex, bit al, bit ar, bit mp);
    vec_t v;
    v.idle = idle; v.ev = ev; v.right = right; v.spd = spd; v.rad = rad;
    v.ex = ex; v.al = al; v.ar = ar; v.mp = mp;
    tbl.push_back(v);
  endfunction

  // reference model state for the two-channel instance
  int mx[2], mlvl[2], mlast[2], mdir[2], mhold[2], mpm[2];
  bit mal[2], mar[2], mmp[2];
  int t;
  int home[2] = '{240, 400};

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      mx[c] = home[c]; mlvl[c] = 0; mlast[c] = -1000000; mdir[c] = 0;
      mhold[c] = 0; mpm[c] = 0; mal[c] = 0; mar[c] = 0; mmp[c] = 0;
    end
    t = 0;
  endfunction

  function automatic void model_cycle();
    for (int c = 0; c < 2; c++) begin
      int r, lo, hi, x, dir, step, nx;
      bit req;
      r = int'(rad2[6*c +: 6]);
      lo = 160 + r; hi = 480 - r; x = mx[c];
      req = 0; dir = 0; mmp[c] = 0;
      if (rc2) begin
        x = home[c]; mlvl[c] = 0; mlast[c] = t; mhold[c] = 0;
      end else if (!en2) begin
        mlvl[c] = 0; mlast[c] = t; mhold[c] = 0;
      end else begin
        if (int'(md2) != mpm[c]) begin mlvl[c] = 0; mhold[c] = 0; end
        if (!md2) begin
          req = ev2[c]; dir = int'(rr2[c]); mhold[c] = 0;
        end else if (bl2[c] != br2[c]) begin
          req = (mhold[c] % P == 0); dir = int'(br2[c]); mhold[c]++;
        end else begin
          mlvl[c] = 0; mhold[c] = 0;
        end
        if (req) begin
          if (dir == mdir[c] && t - mlast[c] < W) mlvl[c] = (mlvl[c] + 1 > 2) ? 2 : mlvl[c] + 1;
          else mlvl[c] = 0;
          step = int'(sp2) * (1 << mlvl[c]);
          if (dir == 1) nx = (x + step + r < 480) ? x + step : hi;
          else          nx = (x > lo + step) ? x - step : lo;
          mmp[c] = (nx != x);
          x = nx; mlast[c] = t; mdir[c] = dir;
        end else begin
          if (x < lo) x = lo;
          if (x > hi) x = hi;
        end
      end
      mpm[c] = int'(md2);
      mx[c] = x;
      mal[c] = (x == lo);
      mar[c] = (x == hi);
    end
    t++;
  endfunction

  initial begin
    int pulses;
    reset_n = 1'b0;
    en1 = 1; rc1 = 0; md1 = 0; ev1 = 0; rr1 = 0; bl1 = 0; br1 = 0; sp1 = 4; rad1 = 16;
    en2 = 1; rc2 = 0; md2 = 0; ev2 = 0; rr2 = 0; bl2 = 0; br2 = 0; sp2 = 4; rad2 = {6'd16, 6'd16};
    #22 reset_n = 1'b1;
    #1;

    // reset state
    check("rst x1", x1, 320);
    check("rst y1", y1, 472);
    check("rst flags1", int'({al1, ar1, mp1}), 0);
    check("rst x2 ch0", x2[9:0], 240);
    check("rst x2 ch1", x2[19:10], 400);
    check("rst y2 ch0", y2[9:0], 472);
    check("rst y2 ch1", y2[19:10], 456);

    // simultaneous events on both channels, then recenter beating an event
    tick();
    ev2 = 2'b11; rr2 = 2'b11;
    tick();
    check("dual x ch0", x2[9:0], 244);
    check("dual x ch1", x2[19:10], 404);
    check("dual pulse", int'(mp2), 3);
    rc2 = 1;
    tick();
    rc2 = 0; ev2 = 0;
    check("recenter x ch0", x2[9:0], 240);
    check("recenter x ch1", x2[19:10], 400);
    check("recenter pulse", int'(mp2), 0);

    // directed vector table on the single-channel instance
    add(9, 1, 1, 4, 16, 324, 0, 0, 1);
    add(9, 1, 1, 4, 16, 332, 0, 0, 1);
    add(9, 1, 1, 4, 16, 348, 0, 0, 1);
    add(9, 1, 1, 4, 16, 364, 0, 0, 1);
    add(9, 1, 0, 4, 16, 360, 0, 0, 1);
    add(50, 1, 0, 4, 16, 356, 0, 0, 1);
    add(50, 1, 1, 4, 16, 360, 0, 0, 1);
    add(0, 1, 1, 4, 16, 368, 0, 0, 1);
    add(0, 1, 1, 4, 16, 384, 0, 0, 1);
    add(0, 1, 1, 4, 16, 400, 0, 0, 1);
    add(0, 1, 1, 4, 16, 416, 0, 0, 1);
    add(0, 1, 1, 4, 16, 432, 0, 0, 1);
    add(0, 1, 1, 4, 16, 448, 0, 0, 1);
    add(50, 1, 1, 4, 16, 452, 0, 0, 1);
    add(50, 1, 1, 4, 16, 456, 0, 0, 1);
    add(50, 1, 1, 4, 16, 460, 0, 0, 1);
    add(50, 1, 1, 4, 16, 464, 0, 1, 1);
    add(0, 1, 1, 4, 16, 464, 0, 1, 0);
    add(0, 0, 0, 4, 32, 448, 0, 1, 0);
    add(0, 0, 0, 4, 16, 448, 0, 0, 0);
    add(50, 1, 0, 30, 16, 418, 0, 0, 1);
    add(0, 1, 0, 30, 16, 358, 0, 0, 1);
    add(0, 1, 0, 30, 16, 238, 0, 0, 1);
    add(50, 1, 0, 30, 16, 208, 0, 0, 1);
    add(50, 1, 0, 30, 16, 178, 0, 0, 1);
    add(50, 1, 0, 4, 16, 176, 1, 0, 1);
    add(0, 1, 0, 4, 16, 176, 1, 0, 0);

    foreach (tbl[i]) begin
      sp1 = 5'(tbl[i].spd); rad1 = 6'(tbl[i].rad);
      repeat (tbl[i].idle) tick();
      ev1 = tbl[i].ev; rr1 = tbl[i].right;
      tick();
      ev1 = 0;
      check($sformatf("vec%0d x", i), x1, tbl[i].ex);
      check($sformatf("vec%0d flags", i), int'({al1, ar1, mp1}),
            int'({tbl[i].al, tbl[i].ar, tbl[i].mp}));
    end

    // button hold for 3*P+1 cycles: four moves with rising step
    md1 = 1; br1 = 1; pulses = 0;
    repeat (3 * P + 1) begin tick(); pulses += int'(mp1); end
    check("hold pulses", pulses, 4);
    check("hold x", x1, 220);
    bl1 = 1; pulses = 0;
    repeat (45) begin tick(); pulses += int'(mp1); end
    check("both btn pulses", pulses, 0);
    check("both btn x", x1, 220);
    bl1 = 0; br1 = 0; md1 = 0;

    // disabled: event ignored
    tick();
    en1 = 0; ev1 = 1; rr1 = 1;
    tick();
    check("disabled x", x1, 220);
    check("disabled pulse", int'(mp1), 0);
    en1 = 1;
    rc1 = 1;
    tick();
    rc1 = 0; ev1 = 0;
    check("recenter1 x", x1, 320);
    check("recenter1 pulse", int'(mp1), 0);

    // asynchronous reset mid-operation
    ev1 = 1; rr1 = 0;
    tick();
    ev1 = 0;
    reset_n = 1'b0;
    #1;
    check("async rst x1", x1, 320);
    check("async rst flags1", int'({al1, ar1, mp1}), 0);
    check("async rst x2", int'(x2), (400 << 10) | 240);
    #1 reset_n = 1'b1;
    model_reset();

    // randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 199) == 0) md2 = ~md2;
      rc2 = ($urandom_range(0, 299) == 0);
      en2 = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < 2; c++) begin
        ev2[c] = ($urandom_range(0, 3) == 0);
        rr2[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 29) == 0) begin
          bl2[c] = 1'($urandom_range(0, 1));
          br2[c] = 1'($urandom_range(0, 1));
        end
        if ($urandom_range(0, 49) == 0) rad2[6*c +: 6] = 6'($urandom_range(8, 40));
      end
      if ($urandom_range(0, 99) == 0) sp2 = 5'($urandom_range(0, 31));
      model_cycle();
      tick();
      for (int c = 0; c < 2; c++) begin
        check($sformatf("rand t%0d ch%0d x", n, c), int'(x2[10*c +: 10]), mx[c]);
        check($sformatf("rand t%0d ch%0d flags", n, c), int'({al2[c], ar2[c], mp2[c]}),
              int'({mal[c], mar[c], mmp[c]}));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
